led_matrix_scan_driver: RTL

Parametrised, double-buffered LED matrix scan driver: next generation of the 8x8 column-scan driver. It accepts a serial bitmap over a clock-synchronous shift interface and holds it in a shadow chain. On a latch request it transfers the frame to a display buffer, but only at a frame boundary, so the display never tears. It scans columns one-hot with a programmable dwell, per-frame brightness PWM and anti-ghost blanking, and sits between the pad ring (ui/uio) and the external column/row transistor drivers.

---
 rtl/led_matrix_scan_driver.sv | 129 ++++++++++++
 1 files changed

// File: rtl/led_matrix_scan_driver.sv
// Double-buffered one-hot column scan driver with tear-free frame latch, brightness PWM
// and anti-ghost blanking (enabled by defining LED_MATRIX_BLANK_EN).
module led_matrix_scan_driver #(
  parameter int NCOLS     = 8,
  parameter int NROWS     = 8,
  parameter int SCAN_DIV  = 16,
  parameter int BLANK_CYC = 2,
  parameter int BRIGHT_W  = $clog2(SCAN_DIV) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                shift_in,
  input  logic                shift_en,
  input  logic                latch,
  input  logic [BRIGHT_W-1:0] brightness,
  output logic [NROWS-1:0]    col_data,
  output logic [NCOLS-1:0]    col_select,
  output logic                latch_pending,
  output logic                frame_start
);

  localparam int NBITS = NCOLS * NROWS;
  localparam int DW    = $clog2(SCAN_DIV);
  localparam int CW    = (NCOLS > 1) ? $clog2(NCOLS) : 1;
`ifdef LED_MATRIX_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif
  localparam int BLANK_EFF = BLANK_EN ? BLANK_CYC : 0;
  localparam logic [DW-1:0]       D_LAST    = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]       C_LAST    = CW'(NCOLS - 1);
  localparam logic [BRIGHT_W-1:0] BR_MAX    = BRIGHT_W'(SCAN_DIV - BLANK_EFF);
  localparam logic [BRIGHT_W:0]   BLANK_EXT = (BRIGHT_W + 1)'(BLANK_EFF);

  logic [NBITS-1:0]    chain_q, chain_d;
  logic [NBITS-1:0]    vbuf_q, vbuf_d;
  logic [DW-1:0]       d_q, d_d;
  logic [CW-1:0]       c_q, c_d;
  logic [BRIGHT_W-1:0] bright_q, bright_d;
  logic                latch_q;
  logic                pend_q, pend_d;
  logic [NROWS-1:0]    col_data_q, col_data_d;
  logic [NCOLS-1:0]    col_select_q, col_select_d;
  logic                frame_start_q, frame_start_d;

  logic              latch_edge;
  logic              boundary;
  logic              lit;
  logic [BRIGHT_W:0] d_ext;
  logic [BRIGHT_W:0] br_ext;

  assign d_ext  = (BRIGHT_W + 1)'(d_q);
  assign br_ext = (BRIGHT_W + 1)'(bright_q);

  generate
    if (BLANK_EFF > 0) begin : g_blank
      assign lit = (d_ext >= BLANK_EXT) && (d_ext < BLANK_EXT + br_ext);
    end else begin : g_noblank
      assign lit = d_ext < br_ext;
    end
  endgenerate

  always_comb begin
    chain_d      = shift_en ? {chain_q[NBITS-2:0], shift_in} : chain_q;
    latch_edge   = latch & ~latch_q;
    boundary     = ena && (d_q == D_LAST) && (c_q == C_LAST);
    vbuf_d       = vbuf_q;
    pend_d       = pend_q;
    bright_d     = bright_q;
    d_d          = d_q;
    c_d          = c_q;

    // Transfer captures the chain including a shift landing on the boundary cycle.
    if (boundary) begin
      if (pend_q || latch_edge) vbuf_d = chain_d;
      pend_d   = 1'b0;
      bright_d = (brightness > BR_MAX) ? BR_MAX : brightness;
    end else if (latch_edge) begin
      pend_d = 1'b1;
    end

    if (ena) begin
      if (d_q == D_LAST) begin
        d_d = '0;
        c_d = (c_q == C_LAST) ? '0 : c_q + 1'b1;
      end else begin
        d_d = d_q + 1'b1;
      end
    end

    col_select_d  = ena ? (NCOLS'(1) << c_q) : '0;
    col_data_d    = (ena && lit) ? vbuf_q[c_q*NROWS +: NROWS] : '0;
    frame_start_d = ena && (c_q == '0) && (d_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q       <= '0;
      vbuf_q        <= '0;
      d_q           <= '0;
      c_q           <= '0;
      bright_q      <= '0;
      latch_q       <= 1'b0;
      pend_q        <= 1'b0;
      col_data_q    <= '0;
      col_select_q  <= '0;
      frame_start_q <= 1'b0;
    end else begin
      chain_q       <= chain_d;
      vbuf_q        <= vbuf_d;
      d_q           <= d_d;
      c_q           <= c_d;
      bright_q      <= bright_d;
      latch_q       <= latch;
      pend_q        <= pend_d;
      col_data_q    <= col_data_d;
      col_select_q  <= col_select_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign col_data      = col_data_q;
  assign col_select    = col_select_q;
  assign latch_pending = pend_q;
  assign frame_start   = frame_start_q;

endmodule
